// File: rtl/onchip_mem_s2_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_s2_arbiter
//
// Shares the s2 port of a dual-port on-chip memory between NUM_REQ fabric-side
// requesters. It issues at most one access per cycle and grants round-robin
// from a rotating pointer. A requester can hold the port across several beats
// by keeping req_lock high. Read data goes back to the requester that issued
// the read. A tag pipeline whose length matches the memory read latency does
// the routing, so data always returns in issue order.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   ADDR_W    s2 word-address width
//   DATA_W    data width (byteenable width is DATA_W/8)
//   READ_LAT  memory s2 read latency in cycles (1 or 2)
//
// Ports
//   clk, reset     single clock; synchronous active-high reset
//   req            per-requester request, held by the requester until gnt
//   req_lock       with req, the owner keeps the port on the next cycle
//   req_write      1 = write, 0 = read
//   req_addr       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata      packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_be         packed byteenables, requester i at [i*DATA_W/8 +: DATA_W/8]
//   gnt            one-hot combinational grant (request accepted this cycle)
//   rvalid         one-hot read-data-valid toward the originating requester
//   rdata          shared read data, qualified by rvalid
//   s2_*           registered Avalon-MM command toward the memory s2 slave
//   s2_readdata    memory read data
//
// Timing: a grant in cycle N puts the command on s2 during N+1. Read data
// appears on rvalid/rdata during N+1+READ_LAT.
// -----------------------------------------------------------------------------
module onchip_mem_s2_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_be,

  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_W-1:0]             rdata,

  output logic [ADDR_W-1:0]             s2_address,
  output logic [DATA_W-1:0]             s2_writedata,
  output logic [DATA_W/8-1:0]           s2_byteenable,
  output logic                          s2_chipselect,
  output logic                          s2_write,
  output logic                          s2_clken,
  input  logic [DATA_W-1:0]             s2_readdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One stage covers the command register and READ_LAT stages cover the memory.
  localparam int PIPE_D = 1 + READ_LAT;

  typedef enum logic {
    ARB   = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr_next;

  // Per-requester views of the packed command buses.
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [BE_W-1:0]   be_arr    [NUM_REQ];

  tag_t tag_pipe [PIPE_D];
  tag_t tag_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    assign be_arr[i]    = req_be[i*BE_W +: BE_W];
  end

  // ---------------------------------------------------------------------------
  // Selection: in OWNED only the owner can win. In ARB the first requester at
  // or above ptr wins, wrapping to 0. Reset suppresses every grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (state == OWNED) begin
      sel_valid = req[owner];
      sel_idx   = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
        if (!sel_valid && req[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = cand;
        end
      end
    end
    if (reset) begin
      sel_valid = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (sel_valid) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  assign ptr_next = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Arbitration FSM. The pointer moves only on an ARB grant. Beats granted in
  // OWNED go to the requester that ARB already passed, so they leave ptr as is.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so that
      // every register samples values from before the edge, whatever the order
      // of the statements.
      case (state)
        ARB: begin
          if (sel_valid) begin
            ptr <= ptr_next;
            if (req_lock[sel_idx]) begin
              state <= OWNED;
              owner <= sel_idx;
            end
          end
        end
        OWNED: begin
          // Leave when the owner drops req (no grant) or sends an unlocked beat.
          if (!sel_valid || !req_lock[owner]) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // s2 command register. When no grant is issued the data fields keep their
  // last value and only the strobes drop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_chipselect <= 1'b0;
      s2_write      <= 1'b0;
      s2_clken      <= 1'b0;
      s2_address    <= '0;
      s2_writedata  <= '0;
      s2_byteenable <= '0;
    end else begin
      s2_clken      <= 1'b1;
      s2_chipselect <= sel_valid;
      s2_write      <= sel_valid & req_write[sel_idx];
      if (sel_valid) begin
        s2_address    <= addr_arr[sel_idx];
        s2_writedata  <= wdata_arr[sel_idx];
        s2_byteenable <= be_arr[sel_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline. Stage 0 runs alongside the command register. The last
  // stage lines up with s2_readdata.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this storage is cleared on reset on purpose. Flushing it is what
      // stops reads in flight at reset from ever raising rvalid.
      for (int k = 0; k < PIPE_D; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: sel_valid & ~req_write[sel_idx], idx: sel_idx};
      for (int k = 1; k < PIPE_D; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_out = tag_pipe[PIPE_D-1];

  // Return path. Gating by reset keeps rvalid/rdata at 0 in the first reset
  // cycle too, before the flush has taken effect.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_out.valid && !reset) begin
      rvalid[tag_out.idx] = 1'b1;
      rdata               = s2_readdata;
    end
  end

endmodule

// File: tb/tb_onchip_mem_s2_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for onchip_mem_s2_arbiter. It runs two instances (READ_LAT=1 and
// READ_LAT=2) on the same requester stimulus, each attached to its own simple
// memory. A transaction-level reference model predicts grants, the s2 command
// and the ordered read returns. Directed scenarios are followed by random
// traffic.
// -----------------------------------------------------------------------------
module tb_onchip_mem_s2_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req, req_lock, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*BW-1:0] req_be;

  // Outputs of both instances; index 0 is READ_LAT=1, index 1 is READ_LAT=2.
  logic [NR-1:0] gnt_o    [2];
  logic [NR-1:0] rvalid_o [2];
  logic [DW-1:0] rdata_o  [2];
  logic [AW-1:0] addr_o   [2];
  logic [DW-1:0] wdata_o  [2];
  logic [BW-1:0] be_o     [2];
  logic          cs_o     [2];
  logic          wr_o     [2];
  logic          clken_o  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [NR-1:0] gnt, rvalid;
    logic [DW-1:0] rdata, s2_writedata, s2_readdata;
    logic [AW-1:0] s2_address;
    logic [BW-1:0] s2_byteenable;
    logic          s2_chipselect, s2_write, s2_clken;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd0, rd1;

    onchip_mem_s2_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .READ_LAT(g + 1)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_lock     (req_lock),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_be       (req_be),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .s2_address   (s2_address),
      .s2_writedata (s2_writedata),
      .s2_byteenable(s2_byteenable),
      .s2_chipselect(s2_chipselect),
      .s2_write     (s2_write),
      .s2_clken     (s2_clken),
      .s2_readdata  (s2_readdata)
    );

    // Memory s2 port: synchronous read, plus an optional output register.
    initial begin
      for (int k = 0; k < 1024; k++) mem[k] <= '0;
    end

    always @(posedge clk) begin
      if (s2_clken && s2_chipselect) begin
        if (s2_write) begin
          for (int b = 0; b < BW; b++) begin
            if (1'(s2_byteenable >> b)) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
          end
        end else begin
          rd0 <= mem[s2_address];
        end
      end
      rd1 <= rd0;
    end

    assign s2_readdata = (g == 0) ? rd0 : rd1;

    assign gnt_o[g]    = gnt;
    assign rvalid_o[g] = rvalid;
    assign rdata_o[g]  = rdata;
    assign addr_o[g]   = s2_address;
    assign wdata_o[g]  = s2_writedata;
    assign be_o[g]     = s2_byteenable;
    assign cs_o[g]     = s2_chipselect;
    assign wr_o[g]     = s2_write;
    assign clken_o[g]  = s2_clken;
  end

  // ---------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bit_of(input logic [NR-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  // ---------------------------------------------------------- reference model
  typedef struct {
    int            issue;
    int            who;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];          // reads issued since the last reset, in order
  int            head [2];       // next read to return, per instance
  int            cyc;
  int            ptr_m, owner_m;
  bit            owned_m;
  logic [DW-1:0] ref_mem [1024];
  bit            pcs, pwr, pclk;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwd;
  logic [BW-1:0] pbe;

  logic [NR-1:0] obs_gnt;
  logic [NR-1:0] obs_rv [2];
  logic [DW-1:0] obs_rd [2];
  logic          obs_cs;

  // Per-requester stimulus.
  bit            d_req [NR];
  bit            d_lock[NR];
  bit            d_wr  [NR];
  logic [AW-1:0] d_ad  [NR];
  logic [DW-1:0] d_wd  [NR];
  logic [BW-1:0] d_be  [NR];

  task automatic apply();
    req = '0; req_lock = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < NR; i++) begin
      req       |= NR'(d_req[i]) << i;
      req_lock  |= NR'(d_lock[i]) << i;
      req_write |= NR'(d_wr[i]) << i;
      req_addr  |= (NR*AW)'(d_ad[i]) << (i*AW);
      req_wdata |= (NR*DW)'(d_wd[i]) << (i*DW);
      req_be    |= (NR*BW)'(d_be[i]) << (i*BW);
    end
  endtask

  task automatic drive(input int i, input bit l, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    d_req[i] = 1'b1; d_lock[i] = l; d_wr[i] = w; d_ad[i] = a; d_wd[i] = d; d_be[i] = b;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) begin
      d_req[i] = 1'b0; d_lock[i] = 1'b0;
    end
  endtask

  // One clock cycle: predict, compare, advance the model, cross the edge.
  // It is entered 1 time unit after a rising edge.
  task automatic step();
    int            gi;
    logic [NR-1:0] eg, erv;
    logic [DW-1:0] erd;
    apply();
    #3;
    if (reset) begin
      rq.delete();
      head[0] = 0;
      head[1] = 0;
    end
    gi = -1;
    if (!reset) begin
      if (owned_m) begin
        if (bit_of(req, owner_m)) gi = owner_m;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (gi < 0 && bit_of(req, (ptr_m + k) % NR)) gi = (ptr_m + k) % NR;
        end
      end
    end
    eg = '0;
    if (gi >= 0) eg = NR'(1) << gi;

    obs_gnt = gnt_o[0];
    obs_cs  = cs_o[0];
    for (int g = 0; g < 2; g++) begin
      check($sformatf("gnt[lat%0d]", g + 1), gnt_o[g], eg);
      erv = '0;
      erd = '0;
      if (head[g] < rq.size() && rq[head[g]].issue + 2 + g == cyc) begin
        erv = NR'(1) << rq[head[g]].who;
        erd = rq[head[g]].data;
        head[g]++;
      end
      check($sformatf("rvalid[lat%0d]", g + 1), rvalid_o[g], erv);
      if (erv != '0 || reset) check($sformatf("rdata[lat%0d]", g + 1), rdata_o[g], erd);
      check($sformatf("s2_cs[lat%0d]", g + 1), cs_o[g], pcs);
      check($sformatf("s2_write[lat%0d]", g + 1), wr_o[g], pwr);
      check($sformatf("s2_clken[lat%0d]", g + 1), clken_o[g], pclk);
      check($sformatf("s2_addr[lat%0d]", g + 1), addr_o[g], paddr);
      check($sformatf("s2_wdata[lat%0d]", g + 1), wdata_o[g], pwd);
      check($sformatf("s2_be[lat%0d]", g + 1), be_o[g], pbe);
      obs_rv[g] = rvalid_o[g];
      obs_rd[g] = rdata_o[g];
    end

    if (reset) begin
      ptr_m = 0; owned_m = 1'b0;
      pcs = 1'b0; pwr = 1'b0; pclk = 1'b0;
      paddr = '0; pwd = '0; pbe = '0;
    end else begin
      pclk = 1'b1;
      if (gi >= 0) begin
        if (!owned_m) begin
          ptr_m = (gi + 1) % NR;
          if (bit_of(req_lock, gi)) begin
            owned_m = 1'b1;
            owner_m = gi;
          end
        end else if (!bit_of(req_lock, gi)) begin
          owned_m = 1'b0;
        end
        pcs   = 1'b1;
        pwr   = bit_of(req_write, gi);
        paddr = AW'(req_addr >> (gi*AW));
        pwd   = DW'(req_wdata >> (gi*DW));
        pbe   = BW'(req_be >> (gi*BW));
        if (pwr) begin
          for (int b = 0; b < BW; b++) begin
            if (1'(pbe >> b)) ref_mem[paddr][b*8 +: 8] = pwd[b*8 +: 8];
          end
        end else begin
          rq.push_back('{issue: cyc, who: gi, data: ref_mem[paddr]});
        end
      end else begin
        owned_m = 1'b0;
        pcs     = 1'b0;
        pwr     = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycles(input int n, input bit allow_reset);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!d_req[i] && $urandom_range(0, 9) < 5) begin
          drive(i, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'(1023 - $urandom_range(0, 7)),
                DW'($urandom), BW'($urandom_range(0, 15)));
        end
      end
      reset = allow_reset && ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < NR; i++) begin
        if (bit_of(obs_gnt, i)) d_req[i] = 1'b0;
      end
    end
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [NR-1:0] acc;
    for (int k = 0; k < 1024; k++) ref_mem[k] = '0;
    idle_all();
    for (int i = 0; i < NR; i++) begin
      d_wr[i] = 1'b0; d_ad[i] = '0; d_wd[i] = '0; d_be[i] = '0;
    end
    reset = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    cyc = 0; ptr_m = 0; owner_m = 0; owned_m = 1'b0;
    head[0] = 0; head[1] = 0;
    pcs = 1'b0; pwr = 1'b0; pclk = 1'b0; paddr = '0; pwd = '0; pbe = '0;
    reset = 1'b0;

    // Reset for 3 cycles in the middle of traffic.
    random_cycles(20, 1'b0);
    drive(0, 1'b0, 1'b0, 10'h001, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 10'h002, '0, 4'hF);
    reset = 1'b1;
    step(); step(); step();
    check("rst_gnt", obs_gnt, '0);
    check("rst_rvalid", obs_rv[0] | obs_rv[1], '0);
    check("rst_rdata", obs_rd[0] | obs_rd[1], '0);
    check("rst_cs", obs_cs, 1'b0);
    reset = 1'b0;
    idle_all();
    drive(0, 1'b0, 1'b0, 10'h001, '0, 4'hF);
    drive(1, 1'b0, 1'b0, 10'h002, '0, 4'hF);
    step();
    check("rst_first_gnt", obs_gnt, 2'b01);
    check("rst_first_cs", obs_cs, 1'b0);

    // Round-robin: bring ptr back to 0, then hold req=11 for 6 cycles.
    idle_all();
    drive(1, 1'b0, 1'b0, 10'h003, '0, 4'hF);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b0, 1'b0, 10'h004, '0, 4'hF);
      drive(1, 1'b0, 1'b0, 10'h006, '0, 4'hF);
      step();
      check($sformatf("rr_gnt%0d", k), obs_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check($sformatf("rr_cs%0d", k), obs_cs, 1'b1);
    end
    idle_all();
    step();
    check("rr_cs6", obs_cs, 1'b1);
    step();
    check("rr_cs_end", obs_cs, 1'b0);
    step();

    // Write then read, single requester.
    drive(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    step();
    drive(0, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    step();
    idle_all();
    step();
    check("wr_no_rvalid", obs_rv[0], '0);
    step();
    check("wr_rd_rvalid", obs_rv[0], 2'b01);
    check("wr_rd_rdata", obs_rd[0], 32'hDEADBEEF);
    step();
    step();

    // Byte-enable merge at the top address.
    drive(0, 1'b0, 1'b1, 10'h3FF, 32'h11223344, 4'hF);
    step();
    drive(0, 1'b0, 1'b1, 10'h3FF, 32'h0000AA00, 4'b0010);
    step();
    drive(0, 1'b0, 1'b0, 10'h3FF, '0, 4'hF);
    step();
    idle_all();
    step();
    step();
    check("be_rvalid_l1", obs_rv[0], 2'b01);
    check("be_rdata_l1", obs_rd[0], 32'h1122AA44);
    step();
    check("be_rvalid_l2", obs_rv[1], 2'b01);
    check("be_rdata_l2", obs_rd[1], 32'h1122AA44);
    step();

    // Locked burst by requester 1 while requester 0 keeps requesting.
    drive(0, 1'b0, 1'b0, 10'h001, '0, 4'hF);
    step();
    for (int b = 0; b < 5; b++) begin
      drive(0, 1'b0, 1'b0, 10'h001, '0, 4'hF);
      drive(1, b < 4, 1'b0, AW'(b), '0, 4'hF);
      step();
      check($sformatf("lock_beat%0d", b), obs_gnt, 2'b10);
    end
    idle_all();
    drive(0, 1'b0, 1'b0, 10'h001, '0, 4'hF);
    step();
    check("lock_release", obs_gnt, 2'b01);
    idle_all();
    repeat (4) step();

    // Two reads, then reset one cycle later: nothing may return.
    drive(0, 1'b0, 1'b0, 10'h3FF, '0, 4'hF);
    step();
    idle_all();
    drive(1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    step();
    idle_all();
    reset = 1'b1;
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) reset = 1'b0;
      step();
      acc |= obs_rv[0] | obs_rv[1];
    end
    check("midrst_no_rvalid", acc, '0);

    // The same two reads without reset: ordered returns at N+3 for READ_LAT=2.
    drive(0, 1'b0, 1'b0, 10'h3FF, '0, 4'hF);
    step();
    idle_all();
    drive(1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    step();
    idle_all();
    step();
    step();
    check("lat2_rv0", obs_rv[1], 2'b01);
    check("lat2_rd0", obs_rd[1], 32'h1122AA44);
    step();
    check("lat2_rv1", obs_rv[1], 2'b10);
    check("lat2_rd1", obs_rd[1], 32'hDEADBEEF);
    step();

    // Random traffic with locks and occasional resets.
    random_cycles(1500, 1'b1);
    idle_all();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_s2_arbiter.md
# onchip_mem_s2_arbiter

Round-robin arbiter that shares the second (s2) port of a dual-port on-chip memory between NUM_REQ fabric-side requesters, alongside the Nios II on port s1. It issues at most one read or write per cycle to s2 and supports locked multi-beat ownership. It returns read data to the originating requester using a latency-matched tag pipeline. It sits in the top level between user logic (KEY/LED handlers, loggers) and the memory's s2 Avalon-MM slave signals.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- ADDR_W, 10: s2 word-address width
- DATA_W, 32: data width; byteenable width is DATA_W/8
- READ_LAT, 1: s2 read latency in cycles (1 or 2, matches memory output-register setting)
- clk  in  1  single clock, same domain as the memory s2 port
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester access request, held until gnt
- req_lock  in  NUM_REQ  while high with req, owner keeps the port next cycle
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_be  in  NUM_REQ*DATA_W/8  packed byteenables
- gnt  out  NUM_REQ  one-hot, combinational; request accepted this cycle
- rvalid  out  NUM_REQ  one-hot read-data-valid
- rdata  out  DATA_W  shared read data, qualified by rvalid
- s2_address, s2_writedata, s2_byteenable  out  ADDR_W / DATA_W / DATA_W/8  registered command fields
- s2_chipselect, s2_write, s2_clken  out  1  registered command strobes
- s2_readdata  in  DATA_W  memory read data

## Operation
- FSM states: ARB and OWNED.
- ARB:
  - Grant the first requester with req=1, scanning from ptr upward with wrap to 0.
  - On grant to requester i, ptr <= (i+1) mod NUM_REQ.
  - If req_lock[i]=1, go to OWNED with owner=i.
- OWNED:
  - Only the owner may be granted. gnt[owner]=req[owner].
  - Requests from all other requesters are ignored.
  - Stay in OWNED while req[owner] and req_lock[owner] are both 1.
  - If req[owner]=1 and req_lock[owner]=0, grant that final beat and return to ARB.
  - If req[owner]=0, return to ARB with no grant that cycle; ptr does not change.
- Command register: on any grant, the next-edge values are s2_chipselect=1, s2_write=req_write[i], and address, wdata and be from requester i. With no grant, s2_chipselect=0 and s2_write=0; other fields hold their last value.
- s2_clken is 0 in reset and 1 in every cycle after reset.
- Read tagging:
  - Each granted read pushes {valid, i} into a shift pipeline of depth 1+READ_LAT.
  - At the pipeline output, rvalid[i]=1 and rdata=s2_readdata.
  - Writes push valid=0.
- Each requester may have unlimited outstanding reads. Data returns strictly in issue order.
- Reset, including mid-operation:
  - Outputs: gnt=0, rvalid=0, rdata=0, all s2_* outputs 0.
  - State returns to ARB; ptr=0, so requester 0 has top priority.
  - The tag pipeline is flushed. Reads in flight at reset never produce rvalid.
- Requester drivers must hold req_* stable until gnt. The arbiter does not check this.

## Timing
- Grant in cycle N (same cycle as req, when selected).
- s2 command visible during cycle N+1; the memory samples it at the end of N+1.
- Read data returns on rvalid/rdata during cycle N+1+READ_LAT: N+2 for READ_LAT=1, N+3 for READ_LAT=2.
- Throughput is one access per cycle; back-to-back grants are allowed, including to the same requester.
- Simultaneous requests: only one grant per cycle. Losers see gnt=0 and keep req asserted.
- Worst-case wait in ARB for an unlocked requester is NUM_REQ-1 cycles, plus any locked bursts by others.
- Read issued in the cycle before reset deasserts: dropped, no rvalid.

## Test plan
- Reset: assert reset 3 cycles during traffic -> all outputs 0. First grant after release goes to requester 0 when req=2'b11.
- Round-robin fairness:
  - Stimulus: req=2'b11 held for 6 cycles, NUM_REQ=2.
  - Required gnt sequence: 01,10,01,10,01,10.
  - Memory shows 6 consecutive chipselect cycles starting N+1.
- Write then read, single requester:
  - Stimulus: write addr 0x005, data 0xDEADBEEF, be 4'hF; next cycle read 0x005.
  - Required: rvalid[0] 2 cycles after the read grant (READ_LAT=1) with rdata=0xDEADBEEF. No rvalid for the write.
- Byte-enable write:
  - Stimulus: write 0x11223344 to 0x3FF (address wrap edge), then be=4'b0010 with 0x0000AA00, then read.
  - Required: rdata=0x1122AA44.
- Locked burst:
  - Stimulus: requester 1 asserts req+lock for 4 beats, then a final beat with lock=0. Requester 0 requests throughout.
  - Required: 5 consecutive gnt[1]. gnt[0] is granted in the cycle after the final beat.
- Mid-burst reset and READ_LAT=2:
  - Stimulus: reset asserted 1 cycle after two reads are issued.
  - Required: no rvalid afterwards.
  - Repeat without reset: rvalid at N+3, in issue order, to the correct requesters.
